// File: rtl/map_tile_fetcher.sv
// map_tile_fetcher
//   Video-side reader of the tile map. Follows the beam, fetches the tile index
//   for the current map cell, then fetches that tile's pixel, producing one
//   8-bit pixel per clock with a fixed 3-clock latency from h_count/v_count.
//   Hardware scroll is double-buffered: loads land in a pending register and
//   are promoted to the active register only at the start of vertical blank,
//   so a frame is never drawn with two different scroll values.
//
// Ports
//   clock, reset_n           pixel clock; asynchronous active-low reset
//   h_count, v_count         beam position from the sync generator
//   scroll_x_in/_y_in        requested scroll in pixels (9-bit, wraps at 512)
//   scroll_load              1-cycle strobe capturing scroll_*_in as pending
//   map_read/_row/_col       map RAM read port (tile index returned on map_data)
//   tile_read/tile_addr      tile RAM read port (pixel returned on tile_data)
//   pixel_out/pixel_valid    pixel stream; pixel_out is 0 outside the visible area
//   in_vblank                beam is in vertical blank
//   frame_start              1-cycle pulse when the beam reaches (0,0)
module map_tile_fetcher #(
    parameter int TILE_BITS = 4,
    parameter int MAP_BITS  = 5,
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [10:0]                h_count,
    input  logic [10:0]                v_count,
    input  logic [TILE_BITS+MAP_BITS-1:0] scroll_x_in,
    input  logic [TILE_BITS+MAP_BITS-1:0] scroll_y_in,
    input  logic                       scroll_load,
    output logic                       map_read,
    output logic [MAP_BITS-1:0]        map_row_index,
    output logic [MAP_BITS-1:0]        map_col_index,
    input  logic [7:0]                 map_data,
    output logic                       tile_read,
    output logic [7+2*TILE_BITS:0]     tile_addr,
    input  logic [7:0]                 tile_data,
    output logic [7:0]                 pixel_out,
    output logic                       pixel_valid,
    output logic                       in_vblank,
    output logic                       frame_start
);

    localparam int PLANE_BITS = TILE_BITS + MAP_BITS;
    localparam int STAGES     = 3;

    typedef struct packed {
        logic [PLANE_BITS-1:0] x;
        logic [PLANE_BITS-1:0] y;
    } scroll_t;

    typedef enum logic [1:0] {
        ST_VISIBLE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    state_t                 state, state_next;
    scroll_t                active_scroll, pending_scroll;
    logic                   pending_valid;

    logic                   visible;
    logic                   beam_origin;
    logic                   apply_point;
    logic [PLANE_BITS-1:0]  vx, vy;

    // vld_pipe[1]: stage-0 result registered, [2]: stage-1, [3]: pixel_valid
    logic [STAGES:1]        vld_pipe;
    logic [TILE_BITS-1:0]   vx_d1, vy_d1;

    // ------------------------------------------------------------------
    // Stage 0: beam decode and virtual-plane coordinates
    // ------------------------------------------------------------------
    always_comb begin
        visible     = (h_count < 11'(H_VISIBLE)) && (v_count < 11'(V_VISIBLE));
        beam_origin = (h_count == 11'd0) && (v_count == 11'd0);
        apply_point = (h_count == 11'd0) && (v_count == 11'(V_VISIBLE));
        // Truncating to PLANE_BITS gives the seamless 512-pixel wrap.
        vx          = h_count[PLANE_BITS-1:0] + active_scroll.x;
        vy          = v_count[PLANE_BITS-1:0] + active_scroll.y;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            map_read      <= 1'b0;
            map_row_index <= '0;
            map_col_index <= '0;
            vx_d1         <= '0;
            vy_d1         <= '0;
        end else begin
            map_read <= visible;
            // Addresses only move on visible pixels; during blank they hold.
            if (visible) begin
                map_row_index <= vy[PLANE_BITS-1:TILE_BITS];
                map_col_index <= vx[PLANE_BITS-1:TILE_BITS];
                vx_d1         <= vx[TILE_BITS-1:0];
                vy_d1         <= vy[TILE_BITS-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: tile RAM address from the returned tile index
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tile_read <= 1'b0;
            tile_addr <= '0;
        end else begin
            tile_read <= vld_pipe[1];
            if (vld_pipe[1])
                tile_addr <= {map_data, vy_d1, vx_d1};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pixel output, forced to 0 outside the visible area
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pixel_out <= 8'd0;
        else
            pixel_out <= vld_pipe[2] ? tile_data : 8'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], visible};
    end

    assign pixel_valid = vld_pipe[STAGES];

    // ------------------------------------------------------------------
    // Beam-region state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ST_VBLANK;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_VISIBLE: begin
                if (h_count == 11'(H_VISIBLE))
                    state_next = ST_HBLANK;
            end
            ST_HBLANK: begin
                if (h_count == 11'd0) begin
                    if (v_count < 11'(V_VISIBLE))
                        state_next = ST_VISIBLE;
                    else if (v_count == 11'(V_VISIBLE))
                        state_next = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (beam_origin)
                    state_next = ST_VISIBLE;
            end
            default: state_next = ST_VBLANK;
        endcase
    end

    // in_vblank tracks the state register but is its own flop so that it
    // reads 0 while reset is held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_vblank   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            in_vblank   <= (state_next == ST_VBLANK);
            frame_start <= beam_origin;
        end
    end

    // ------------------------------------------------------------------
    // Double-buffered scroll. A load coinciding with the apply point lands
    // in pending after the old pending has been promoted, so it waits for
    // the following frame with pending_valid still set.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active_scroll  <= '0;
            pending_scroll <= '0;
            pending_valid  <= 1'b0;
        end else begin
            if (apply_point && pending_valid)
                active_scroll <= pending_scroll;
            if (scroll_load) begin
                pending_scroll <= '{x: scroll_x_in, y: scroll_y_in};
                pending_valid  <= 1'b1;
            end else if (apply_point && pending_valid) begin
                pending_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_map_tile_fetcher.sv
// Scoreboard bench for map_tile_fetcher. The stimulus process drives beam
// positions and pushes expected observations (with the cycle they are due)
// into a queue; a monitor on the falling edge pops and compares them.
module tb_map_tile_fetcher;

    localparam int K_MAP  = 0;
    localparam int K_TILE = 1;
    localparam int K_PIX  = 2;
    localparam int K_ZERO = 3;
    localparam int K_VBL  = 4;
    localparam int K_FS   = 5;

    logic        clock;
    logic        reset_n;
    logic [10:0] h_count, v_count;
    logic [8:0]  scroll_x_in, scroll_y_in;
    logic        scroll_load;
    logic        map_read;
    logic [4:0]  map_row_index, map_col_index;
    logic [7:0]  map_data;
    logic        tile_read;
    logic [15:0] tile_addr;
    logic [7:0]  tile_data;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
    logic        in_vblank;
    logic        frame_start;

    logic [7:0]  map_mem  [0:1023];
    logic [7:0]  tile_mem [0:65535];

    map_tile_fetcher dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .h_count       (h_count),
        .v_count       (v_count),
        .scroll_x_in   (scroll_x_in),
        .scroll_y_in   (scroll_y_in),
        .scroll_load   (scroll_load),
        .map_read      (map_read),
        .map_row_index (map_row_index),
        .map_col_index (map_col_index),
        .map_data      (map_data),
        .tile_read     (tile_read),
        .tile_addr     (tile_addr),
        .tile_data     (tile_data),
        .pixel_out     (pixel_out),
        .pixel_valid   (pixel_valid),
        .in_vblank     (in_vblank),
        .frame_start   (frame_start)
    );

    // RAM models: data tracks the registered address within the same cycle,
    // i.e. the RAM's own output register was loaded from the stage-0 address.
    assign map_data  = map_mem[{map_row_index, map_col_index}];
    assign tile_data = tile_mem[tile_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          kind;
        logic [63:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   k;

    function automatic logic [63:0] actual(input int kind);
        case (kind)
            K_MAP:   return 64'({map_read, map_row_index, map_col_index});
            K_TILE:  return 64'({tile_read, tile_addr});
            K_PIX:   return 64'({pixel_valid, pixel_out});
            K_ZERO:  return 64'({map_read, map_row_index, map_col_index, tile_read,
                                 tile_addr, pixel_out, pixel_valid, in_vblank, frame_start});
            K_VBL:   return 64'(in_vblank);
            default: return 64'(frame_start);
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_MAP:   return "map_port";
            K_TILE:  return "tile_port";
            K_PIX:   return "pixel";
            K_ZERO:  return "reset_zero";
            K_VBL:   return "in_vblank";
            default: return "frame_start";
        endcase
    endfunction

    always @(negedge clock) begin : monitor
        logic [63:0] a;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
                a = actual(q[i].kind);
                n_tests++;
                if (a !== q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %h expected %h",
                             kname(q[i].kind), cyc, a, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    task automatic expect_at(input int due, input int kind, input logic [63:0] exp);
        q.push_back('{due: due, kind: kind, exp: exp});
    endtask

    task automatic step(input int h, input int v);
        @(posedge clock);
        #1;
        h_count     = 11'(h);
        v_count     = 11'(v);
        scroll_load = 1'b0;
        k           = cyc;
    endtask

    task automatic step_ld(input int h, input int v, input int sx, input int sy);
        step(h, v);
        scroll_load = 1'b1;
        scroll_x_in = 9'(sx);
        scroll_y_in = 9'(sy);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) map_mem[i] = 8'h01;
        for (int i = 0; i < 65536; i++)
            tile_mem[i] = ((i >> 8) == 1) ? 8'h11 : ((i >> 8) == 5) ? 8'h55 : 8'h00;
        map_mem[0] = 8'h05;            // cell (0,0)
        map_mem[1] = 8'h07;            // cell (0,1)
        map_mem[2] = 8'h09;            // cell (0,2)
        tile_mem[16'h0500] = 8'hAA;
        tile_mem[16'h0700] = 8'h77;
        tile_mem[16'h0900] = 8'h99;

        reset_n     = 1'b0;
        h_count     = 11'd700;
        v_count     = 11'd500;
        scroll_x_in = '0;
        scroll_y_in = '0;
        scroll_load = 1'b0;

        // Reset state
        @(posedge clock); #1; k = cyc;
        expect_at(k, K_ZERO, 64'd0);
        @(posedge clock); #1; reset_n = 1'b1;

        // Basic fetch at (0,0), scroll 0
        step(0, 0);
        expect_at(k,     K_VBL,  64'd1);
        expect_at(k + 1, K_VBL,  64'd0);
        expect_at(k + 1, K_FS,   64'd1);
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd0}));
        expect_at(k + 2, K_TILE, 64'({1'b1, 16'h0500}));
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'hAA}));
        step(1, 0);
        expect_at(k + 1, K_FS,   64'd0);
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'h55}));
        step(639, 0);            // vx=639 wraps to 127 -> col 7
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd7}));
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'h11}));
        step(640, 0);            // leaves visible; addresses hold
        expect_at(k + 1, K_MAP,  64'({1'b0, 5'd0, 5'd7}));
        expect_at(k + 2, K_TILE, 64'({1'b0, 16'h010F}));
        expect_at(k + 3, K_PIX,  64'({1'b0, 8'h00}));

        // scroll_x = 8, applied at the start of vblank
        step_ld(700, 490, 8, 0);
        step(0, 480);
        expect_at(k + 1, K_VBL,  64'd1);
        step(503, 0);            // vx=511 -> col 31, x 15
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd31}));
        expect_at(k + 2, K_TILE, 64'({1'b1, 16'h010F}));
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'h11}));
        step(504, 0);            // vx wraps to 0
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd0}));
        expect_at(k + 2, K_TILE, 64'({1'b1, 16'h0500}));
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'hAA}));

        // Load 16, then load 32 on the apply cycle itself
        step_ld(5, 200, 16, 0);
        step(504, 0);            // still scroll 8 this frame
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'hAA}));
        step_ld(0, 480, 32, 0);  // applies 16, keeps 32 pending
        step(0, 0);
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd1}));
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'h77}));
        step(0, 480);            // applies 32
        step(0, 0);
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd2}));
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'h99}));

        // Mid-frame load must not take effect until the next apply point
        step_ld(10, 100, 16, 0);
        step(0, 0);
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'h99}));
        step(0, 480);
        step(0, 0);
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd1}));
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'h77}));

        // Region state machine: HBLANK -> VBLANK -> VISIBLE
        step(640, 5);
        expect_at(k + 1, K_VBL,  64'd0);
        step(0, 480);
        expect_at(k + 1, K_VBL,  64'd1);
        step(0, 0);
        expect_at(k + 1, K_VBL,  64'd0);

        // Mid-line reset: 5 clocks low starting at h_count=200
        for (int h = 195; h < 200; h++) step(h, 10);
        step(200, 10);
        reset_n = 1'b0;
        expect_at(k, K_ZERO, 64'd0);
        for (int i = 1; i < 5; i++) begin
            step(200 + i, 10);
            expect_at(k, K_ZERO, 64'd0);
        end
        step(205, 10);
        reset_n = 1'b1;
        expect_at(k,     K_PIX,  64'd0);
        expect_at(k + 1, K_PIX,  64'd0);
        expect_at(k + 2, K_PIX,  64'd0);
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd12}));   // scroll back to 0
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'h11}));
        step(0, 0);
        expect_at(k + 1, K_MAP,  64'({1'b1, 5'd0, 5'd0}));
        expect_at(k + 3, K_PIX,  64'({1'b1, 8'hAA}));
        step(700, 500);

        repeat (6) @(posedge clock);
        #1;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
            n_tests += q.size();
            n_fail  += q.size();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
